// File: rtl/sprite_list_writer.sv
// Avalon-MM slave holding a shadow sprite list. Software fills the list and
// requests a commit; the packed list is handed to the renderer at the start
// of the next vertical sync so a frame never shows a half-updated list.
module sprite_list_writer #(
  parameter int NUM_SPRITES = 20,
  parameter int ENTRY_W     = 25,
  parameter int OUT_W       = 512
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             chipselect,
  input  logic             write,
  input  logic             read,
  input  logic [4:0]       address,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic             vga_vs,
  output logic [OUT_W-1:0] gl_input,
  output logic             gl_write
);

  localparam logic [4:0] ADDR_COMMIT = 5'd20;
  localparam logic [4:0] ADDR_CLEAR  = 5'd21;
  localparam logic [4:0] ADDR_FRAMES = 5'd22;
  localparam logic [4:0] ADDR_XFERS  = 5'd23;

  logic [ENTRY_W-1:0] shadow_q [NUM_SPRITES];
  logic [ENTRY_W-1:0] shadow_d [NUM_SPRITES];
  logic [OUT_W-1:0]   gl_input_q, gl_input_d;
  logic               gl_write_q, gl_write_d;
  logic [31:0]        readdata_q, readdata_d;
  logic               pending_q, pending_d;
  logic [15:0]        frame_count_q, frame_count_d;
  logic [15:0]        xfer_count_q, xfer_count_d;
  logic               vs_q, vs_d;

  logic               wr_en, rd_en, vs_fall, xfer, commit, clear;
  logic [OUT_W-1:0]   packed_list;
  logic [31:0]        rd_val;

  // Entry bits above the sprite word are don't-care on writes.
  logic unused_wdata;
  assign unused_wdata = ^writedata[31:ENTRY_W];

  // Bus qualifiers and the vsync falling-edge / transfer decision.
  always_comb begin
    wr_en   = chipselect & write;
    rd_en   = chipselect & read;
    vs_fall = vs_q & ~vga_vs;
    xfer    = vs_fall & pending_q;
    commit  = wr_en && (address == ADDR_COMMIT) && writedata[0];
    clear   = wr_en && (address == ADDR_CLEAR) && writedata[0];
  end

  // Pack the shadow list (pre-edge values) into the renderer bus layout.
  always_comb begin
    packed_list = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      packed_list[ENTRY_W*i +: ENTRY_W] = shadow_q[i];
    end
  end

  // Read mux; uses pre-edge state so a same-cycle write returns the old value.
  always_comb begin
    rd_val = '0;
    case (address)
      ADDR_COMMIT: rd_val[0]    = pending_q;
      ADDR_FRAMES: rd_val[15:0] = frame_count_q;
      ADDR_XFERS:  rd_val[15:0] = xfer_count_q;
      default: begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
          if (address == 5'(i)) rd_val[ENTRY_W-1:0] = shadow_q[i];
        end
      end
    endcase
  end

  // Next-state for shadow list, commit flag, counters and outputs.
  always_comb begin
    shadow_d = shadow_q;
    if (clear) begin
      for (int i = 0; i < NUM_SPRITES; i++) shadow_d[i] = '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (address == 5'(i)) shadow_d[i] = writedata[ENTRY_W-1:0];
      end
    end

    // A commit landing on the transfer edge re-arms for the next frame.
    pending_d = pending_q;
    if (xfer)   pending_d = 1'b0;
    if (commit) pending_d = 1'b1;

    frame_count_d = vs_fall ? frame_count_q + 16'd1 : frame_count_q;
    xfer_count_d  = xfer ? xfer_count_q + 16'd1 : xfer_count_q;
    gl_input_d    = xfer ? packed_list : gl_input_q;
    gl_write_d    = xfer;
    readdata_d    = rd_en ? rd_val : readdata_q;
    vs_d          = vga_vs;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shadow_q      <= '{default: '0};
      gl_input_q    <= '0;
      gl_write_q    <= 1'b0;
      readdata_q    <= '0;
      pending_q     <= 1'b0;
      frame_count_q <= '0;
      xfer_count_q  <= '0;
      vs_q          <= 1'b1;
    end else begin
      shadow_q      <= shadow_d;
      gl_input_q    <= gl_input_d;
      gl_write_q    <= gl_write_d;
      readdata_q    <= readdata_d;
      pending_q     <= pending_d;
      frame_count_q <= frame_count_d;
      xfer_count_q  <= xfer_count_d;
      vs_q          <= vs_d;
    end
  end

  assign gl_input = gl_input_q;
  assign gl_write = gl_write_q;
  assign readdata = readdata_q;

endmodule

// File: doc/sprite_list_writer.md
Name: sprite_list_writer

Overview:
- CPU-facing Avalon-MM slave that produces the sprite display list consumed by the VGA sprite renderer.
- Holds a shadow copy of NUM_SPRITES sprite entries. Each entry is {id[24:20], x[19:10], y[9:0]}.
- Software writes entries and then requests a commit. The block packs the shadow list onto gl_input and pulses gl_write at the start of vertical sync, so the renderer never sees a half-updated frame.
- Sits between the HPS/Nios Avalon bus and the gl_input/write inputs of the VGA top.

Parameters:
- NUM_SPRITES, 20, number of sprite entries (must be 1..20).
- ENTRY_W, 25, bits per sprite entry.
- OUT_W, 512, width of packed output bus. NUM_SPRITES*ENTRY_W <= OUT_W is required.

Ports:
- clk  input  1  system clock (50 MHz, same domain as the VGA timing generator).
- reset  input  1  synchronous, active-low reset.
- chipselect  input  1  Avalon slave select.
- write  input  1  Avalon write strobe; qualified by chipselect.
- read  input  1  Avalon read strobe; qualified by chipselect.
- address  input  5  word address.
- writedata  input  32  write data.
- readdata  output  32  registered read data.
- vga_vs  input  1  VGA vertical sync, active-low, synchronous to clk.
- gl_input  output  OUT_W  packed sprite list. Entry i occupies bits [ENTRY_W*i+ENTRY_W-1 : ENTRY_W*i]; unused upper bits are 0.
- gl_write  output  1  one-cycle load strobe to the renderer.

Behaviour:
- Reset: reset==0 sampled at posedge clk. All of the following are cleared:
  - shadow entries, gl_input, readdata, pending, frame_count, xfer_count → 0.
  - gl_write → 0.
  - vs_q → 1.
- Reset mid-operation: any pending commit is discarded and no gl_write pulse is issued.
- Register map, writes (chipselect & write):
  - 0..NUM_SPRITES-1: shadow[address] <= writedata[24:0]; bits [31:25] are ignored.
  - 20 COMMIT: if writedata[0]==1, set pending.
  - 21 CLEAR: if writedata[0]==1, zero all shadow entries in one cycle. gl_input is unaffected.
  - Any other address (including NUM_SPRITES..19 when NUM_SPRITES<20): no effect.
- Register map, reads (chipselect & read), registered with latency 1:
  - 0..NUM_SPRITES-1: {7'b0, shadow[address]}.
  - 20: {31'b0, pending}.
  - 22: {16'b0, frame_count}.
  - 23: {16'b0, xfer_count}.
  - Any other address: 0.
  - When no read occurs, readdata holds its previous value.
  - A read and a write to the same entry in the same cycle returns the old value.
- Vsync edge detection:
  - vs_q <= vga_vs every cycle.
  - vs_fall = vs_q & ~vga_vs.
  - frame_count increments on every vs_fall and wraps from 0xFFFF to 0.
- Transfer: on a posedge where vs_fall && pending:
  - gl_input <= pack(shadow), using shadow values from before this edge. A shadow write in the same cycle is not included.
  - gl_write <= 1, for exactly the following cycle.
  - xfer_count increments (16-bit, wraps).
  - pending is cleared.
- gl_write is 0 in every other cycle. gl_input holds its value between transfers.
- COMMIT in the same cycle as vs_fall:
  - pending==0: pending becomes 1 and no transfer occurs this frame. The transfer happens at the next vs_fall.
  - pending==1: the transfer occurs and pending remains 1, because set has priority over clear. A second transfer follows at the next vs_fall.
- Multiple COMMITs within one frame collapse into a single transfer.
- CLEAR followed by COMMIT: the next transfer drives all-zero entries onto gl_input.
- At most one transfer per frame. gl_write pulses are separated by at least one full frame.

Test Plan:
- Reset then idle for 3 frames with vga_vs toggling:
  - gl_write never asserts and gl_input==0.
  - Read addr 22 returns 3; read addr 23 returns 0.
- Write addr0=0x010_0A05 and addr2=0x0300C80, then COMMIT:
  - Exactly one gl_write pulse, starting 1 cycle after the next vga_vs falling edge.
  - gl_input[24:0]==0x0100A05, gl_input[74:50]==0x0300C80, all other bits 0.
  - Read addr 20 returns 0 afterwards.
- Write entry 1 = X in the same cycle as vs_fall with pending=1:
  - The transfer carries the old entry 1.
  - A second COMMIT then transfers X one frame later.
- COMMIT in the vs_fall cycle with pending=0: no pulse that frame; one pulse at the next falling edge. Three COMMITs in one frame: exactly one pulse.
- Load entries, then CLEAR, then COMMIT:
  - Read addr 0 returns 0.
  - After vs_fall, gl_input==0 with one gl_write pulse.
- Reset asserted (0) while pending=1, released before vs_fall: no gl_write pulse, and all readback registers return 0.
